// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC-32 constants, minimum frame size,
// FCS inserter state encoding and byte-serial CRC helpers.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;
  localparam int          ETH_MIN_FRAME_BYTES  = 60;
  localparam int          LEN_WIDTH            = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    PAD  = 2'd2,
    FCS  = 2'd3
  } fcs_state_t;

  // Fold one byte into a reflected CRC-32, least-significant bit first.
  function automatic logic [31:0] crc32_d8_step(input logic [31:0] crc,
                                                input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC32_POLY_REFLECTED;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Select one byte of the transmitted FCS (~crc), byte 0 goes out first.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc,
                                          input logic [1:0]  idx);
    logic [31:0] fcs;
    logic [7:0]  b;
    fcs = ~crc;
    case (idx)
      2'd0:    b = fcs[7:0];
      2'd1:    b = fcs[15:8];
      2'd2:    b = fcs[23:16];
      2'd3:    b = fcs[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational one-byte CRC-32 update (IEEE 802.3, reflected).
// Shared between the transmit FCS inserter and the receive FCS checker.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Next CRC after folding in one data byte.
  always_comb begin
    crc_out = crc32_d8_step(crc_in, data);
  end

endmodule

// File: rtl/eth_tx_fcs_inserter.sv
// Transmit-side FCS inserter: forwards frame bytes from the packet
// transmitter, zero-pads short frames to the Ethernet minimum, appends the
// 4-byte CRC-32 FCS and presents everything through one registered stage.
module eth_tx_fcs_inserter
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] S_DATA_IN,
  input  logic                  S_DATA_VALID,
  output logic                  S_DATA_READY,
  input  logic                  S_DATA_FIRST,
  input  logic                  S_DATA_LAST,
  output logic [DATA_WIDTH-1:0] M_DATA_OUT,
  output logic                  M_DATA_VALID,
  input  logic                  M_DATA_READY,
  output logic                  M_DATA_FIRST,
  output logic                  M_DATA_LAST,
  output logic [CNT_WIDTH-1:0]  TX_FRAME_COUNT,
  output logic [CNT_WIDTH-1:0]  DROP_COUNT
);

  localparam logic [LEN_WIDTH-1:0] LEN_MAX_C = {LEN_WIDTH{1'b1}};
  localparam logic [31:0]          MIN_LEN_C = 32'(MIN_FRAME_BYTES);

  fcs_state_t state_r;
  fcs_state_t state_nxt_s;

  logic [DATA_WIDTH-1:0] out_data_r;
  logic [DATA_WIDTH-1:0] out_data_nxt_s;
  logic                  out_first_r;
  logic                  out_first_nxt_s;
  logic                  out_last_r;
  logic                  out_last_nxt_s;
  logic                  out_valid_r;
  logic                  out_valid_nxt_s;

  logic [31:0]           crc_r;
  logic [31:0]           crc_nxt_s;
  logic [31:0]           crc_upd_s;
  logic [7:0]            crc_data_s;

  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  len_nxt_s;
  logic [LEN_WIDTH-1:0]  len_inc_s;
  logic [31:0]           len_ext_s;
  logic [1:0]            fcs_idx_r;
  logic [1:0]            fcs_idx_nxt_s;

  logic [CNT_WIDTH-1:0]  frame_cnt_r;
  logic [CNT_WIDTH-1:0]  drop_cnt_r;

  logic                  load_en_s;
  logic                  s_ready_s;
  logic                  accept_s;
  logic                  pad_needed_s;
  logic                  pad_done_s;
  logic                  drop_s;
  logic                  frame_done_s;

  // Byte-serial CRC engine; pad bytes contribute zeros.
  eth_crc32_d8 u_crc (
    .crc_in  (crc_r),
    .data    (crc_data_s),
    .crc_out (crc_upd_s)
  );

  // Handshake and length bookkeeping shared by the FSM and the datapath.
  always_comb begin
    load_en_s    = ~out_valid_r | M_DATA_READY;
    s_ready_s    = ((state_r == IDLE) | (state_r == PASS)) & load_en_s & ~areset;
    accept_s     = S_DATA_VALID & s_ready_s;
    frame_done_s = out_valid_r & M_DATA_READY & out_last_r;
    if (len_r == LEN_MAX_C) begin
      len_inc_s = len_r;
    end else begin
      len_inc_s = len_r + LEN_WIDTH'(1);
    end
    len_ext_s    = {{(32-LEN_WIDTH){1'b0}}, len_inc_s};
    pad_needed_s = (len_ext_s < MIN_LEN_C);
    pad_done_s   = (len_ext_s == MIN_LEN_C);
    if (state_r == PAD) begin
      crc_data_s = 8'h00;
    end else begin
      crc_data_s = S_DATA_IN[7:0];
    end
  end

  // Frame state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision; the last FCS byte returns to IDLE as soon as it is
  // loaded so the next frame can start while that byte is being consumed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && S_DATA_FIRST) begin
          if (S_DATA_LAST) begin
            state_nxt_s = pad_needed_s ? PAD : FCS;
          end else begin
            state_nxt_s = PASS;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PASS: begin
        if (accept_s && S_DATA_LAST) begin
          state_nxt_s = pad_needed_s ? PAD : FCS;
        end else begin
          state_nxt_s = PASS;
        end
      end
      PAD: begin
        if (load_en_s && pad_done_s) begin
          state_nxt_s = FCS;
        end else begin
          state_nxt_s = PAD;
        end
      end
      FCS: begin
        if (load_en_s && (fcs_idx_r == 2'd3)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = FCS;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Per-state datapath control: what goes into the output register and how
  // the CRC, length and FCS byte index advance.
  always_comb begin
    out_data_nxt_s  = out_data_r;
    out_first_nxt_s = out_first_r;
    out_last_nxt_s  = out_last_r;
    out_valid_nxt_s = load_en_s ? 1'b0 : out_valid_r;
    crc_nxt_s       = crc_r;
    len_nxt_s       = len_r;
    fcs_idx_nxt_s   = fcs_idx_r;
    drop_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (S_DATA_FIRST) begin
            out_data_nxt_s  = S_DATA_IN;
            out_first_nxt_s = 1'b1;
            out_last_nxt_s  = 1'b0;
            out_valid_nxt_s = 1'b1;
            crc_nxt_s       = crc_upd_s;
            len_nxt_s       = len_inc_s;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          drop_s = 1'b0;
        end
      end
      PASS: begin
        if (accept_s) begin
          out_data_nxt_s  = S_DATA_IN;
          out_first_nxt_s = 1'b0;
          out_last_nxt_s  = 1'b0;
          out_valid_nxt_s = 1'b1;
          crc_nxt_s       = crc_upd_s;
          len_nxt_s       = len_inc_s;
        end else begin
          drop_s = 1'b0;
        end
      end
      PAD: begin
        if (load_en_s) begin
          out_data_nxt_s  = {DATA_WIDTH{1'b0}};
          out_first_nxt_s = 1'b0;
          out_last_nxt_s  = 1'b0;
          out_valid_nxt_s = 1'b1;
          crc_nxt_s       = crc_upd_s;
          len_nxt_s       = len_inc_s;
        end else begin
          drop_s = 1'b0;
        end
      end
      FCS: begin
        if (load_en_s) begin
          out_data_nxt_s  = DATA_WIDTH'(fcs_byte(crc_r, fcs_idx_r));
          out_first_nxt_s = 1'b0;
          out_last_nxt_s  = (fcs_idx_r == 2'd3);
          out_valid_nxt_s = 1'b1;
          if (fcs_idx_r == 2'd3) begin
            crc_nxt_s     = CRC32_INIT;
            len_nxt_s     = {LEN_WIDTH{1'b0}};
            fcs_idx_nxt_s = 2'd0;
          end else begin
            fcs_idx_nxt_s = fcs_idx_r + 2'd1;
          end
        end else begin
          drop_s = 1'b0;
        end
      end
      default: begin
        drop_s = 1'b0;
      end
    endcase
  end

  // Output register, CRC accumulator, length and FCS byte index.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      crc_r       <= CRC32_INIT;
      len_r       <= {LEN_WIDTH{1'b0}};
      fcs_idx_r   <= 2'd0;
    end else begin
      out_data_r  <= out_data_nxt_s;
      out_first_r <= out_first_nxt_s;
      out_last_r  <= out_last_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      crc_r       <= crc_nxt_s;
      len_r       <= len_nxt_s;
      fcs_idx_r   <= fcs_idx_nxt_s;
    end
  end

  // Debug counters: frames whose last FCS byte left, bytes dropped in IDLE.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_cnt_r <= {CNT_WIDTH{1'b0}};
      drop_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      if (frame_done_s) begin
        frame_cnt_r <= frame_cnt_r + CNT_WIDTH'(1);
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign S_DATA_READY   = s_ready_s;
  assign M_DATA_OUT     = out_data_r;
  assign M_DATA_VALID   = out_valid_r;
  assign M_DATA_FIRST   = out_first_r;
  assign M_DATA_LAST    = out_last_r;
  assign TX_FRAME_COUNT = frame_cnt_r;
  assign DROP_COUNT     = drop_cnt_r;

endmodule

// File: tb/tb_eth_tx_fcs_inserter.sv
// Self-checking bench for eth_tx_fcs_inserter. Two instances share the
// stimulus: one with padding disabled, one with the 60-byte minimum.
module tb_eth_tx_fcs_inserter;

  typedef logic [7:0] bq_t[$];

  logic        aclk      = 1'b0;
  logic        areset    = 1'b1;
  logic [7:0]  s_data    = 8'h00;
  logic        s_valid   = 1'b0;
  logic        s_first   = 1'b0;
  logic        s_last    = 1'b0;
  logic        m_ready   = 1'b1;
  logic        sel       = 1'b0;
  logic        rnd_ready = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        s_ready0, m_valid0, m_first0, m_last0;
  logic [7:0]  m_data0;
  logic [15:0] tx0, drop0;
  logic        s_ready6, m_valid6, m_first6, m_last6;
  logic [7:0]  m_data6;
  logic [15:0] tx6, drop6;
  logic        s_valid0, s_valid6;

  logic        s_ready_m, m_valid, m_first, m_last;
  logic [7:0]  m_data;
  logic [15:0] tx_m, drop_m;

  assign s_valid0  = s_valid & ~sel;
  assign s_valid6  = s_valid & sel;
  assign s_ready_m = sel ? s_ready6 : s_ready0;
  assign m_valid   = sel ? m_valid6 : m_valid0;
  assign m_first   = sel ? m_first6 : m_first0;
  assign m_last    = sel ? m_last6  : m_last0;
  assign m_data    = sel ? m_data6  : m_data0;
  assign tx_m      = sel ? tx6      : tx0;
  assign drop_m    = sel ? drop6    : drop0;

  eth_tx_fcs_inserter #(.DATA_WIDTH(8), .MIN_FRAME_BYTES(0), .CNT_WIDTH(16)) u_dut0 (
    .aclk(aclk), .areset(areset),
    .S_DATA_IN(s_data), .S_DATA_VALID(s_valid0), .S_DATA_READY(s_ready0),
    .S_DATA_FIRST(s_first), .S_DATA_LAST(s_last),
    .M_DATA_OUT(m_data0), .M_DATA_VALID(m_valid0), .M_DATA_READY(m_ready),
    .M_DATA_FIRST(m_first0), .M_DATA_LAST(m_last0),
    .TX_FRAME_COUNT(tx0), .DROP_COUNT(drop0)
  );

  eth_tx_fcs_inserter #(.DATA_WIDTH(8), .MIN_FRAME_BYTES(60), .CNT_WIDTH(16)) u_dut60 (
    .aclk(aclk), .areset(areset),
    .S_DATA_IN(s_data), .S_DATA_VALID(s_valid6), .S_DATA_READY(s_ready6),
    .S_DATA_FIRST(s_first), .S_DATA_LAST(s_last),
    .M_DATA_OUT(m_data6), .M_DATA_VALID(m_valid6), .M_DATA_READY(m_ready),
    .M_DATA_FIRST(m_first6), .M_DATA_LAST(m_last6),
    .TX_FRAME_COUNT(tx6), .DROP_COUNT(drop6)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // MAC ready: always asserted, or a fair coin flip each cycle.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC-32: table-driven, byte at a time.
  logic [31:0] crc_tab [256];

  task automatic build_table();
    logic [31:0] c;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
  endtask

  function automatic logic [31:0] model_fcs(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) c = crc_tab[c[7:0] ^ b[i]] ^ (c >> 8);
    return ~c;
  endfunction

  task automatic build_exp(input bq_t pl, input int minb, output bq_t e);
    logic [31:0] f;
    e = pl;
    while (e.size() < minb) e.push_back(8'h00);
    f = model_fcs(e);
    e.push_back(f[7:0]);
    e.push_back(f[15:8]);
    e.push_back(f[23:16]);
    e.push_back(f[31:24]);
  endtask

  task automatic rand_payload(input int n, output bq_t q);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  // Output monitor: collects transferred bytes, checks stability under stall.
  logic [7:0]  got_d[$];
  logic        got_f[$];
  logic        got_l[$];
  int          last_cycs[$];
  logic        prev_stall = 1'b0;
  logic [10:0] prev_out   = 11'd0;

  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 64'({m_valid, m_first, m_last, m_data}), 64'(prev_out));
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_f.push_back(m_first);
        got_l.push_back(m_last);
        if (m_last) last_cycs.push_back(cyc);
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_valid, m_first, m_last, m_data};
    end
  end

  task automatic drive_byte(input logic [7:0] d, input logic f, input logic l, output int acc_cyc);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    acc_cyc = -1;
    s_data = d; s_first = f; s_last = l; s_valid = 1'b1;
    while (!acc && n < 500) begin
      @(negedge aclk);
      acc = s_ready_m;
      acc_cyc = cyc;
      @(posedge aclk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    chk("in_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_frame(input bq_t q, input int gap_max, output int first_cyc);
    int c;
    first_cyc = -1;
    for (int i = 0; i < q.size(); i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
        @(posedge aclk);
        #1;
      end
      drive_byte(q[i], i == 0, i == q.size() - 1, c);
      if (i == 0) first_cyc = c;
    end
  endtask

  task automatic wait_out(input int n, input string tag);
    int k;
    k = 0;
    while (got_d.size() < n && k < 3000) begin
      @(posedge aclk);
      k++;
    end
    chk({tag, "_count"}, 64'(got_d.size() >= n), 64'd1);
  endtask

  task automatic check_frame(input bq_t e, input string tag);
    wait_out(e.size(), tag);
    for (int i = 0; i < e.size(); i++) begin
      if (got_d.size() == 0) begin
        chk({tag, "_len"}, 64'(i), 64'(e.size()));
        break;
      end
      chk({tag, "_data"},  64'(got_d.pop_front()), 64'(e[i]));
      chk({tag, "_first"}, 64'(got_f.pop_front()), 64'(i == 0));
      chk({tag, "_last"},  64'(got_l.pop_front()), 64'(i == e.size() - 1));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(m_valid),   64'd0);
    chk({tag, "_data"},  64'(m_data),    64'd0);
    chk({tag, "_first"}, 64'(m_first),   64'd0);
    chk({tag, "_last"},  64'(m_last),    64'd0);
    chk({tag, "_ready"}, 64'(s_ready_m), 64'd0);
    chk({tag, "_txcnt"}, 64'(tx_m),      64'd0);
    chk({tag, "_drop"},  64'(drop_m),    64'd0);
  endtask

  task automatic settle();
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin
    bq_t  pl, pb, e, eb;
    int   fa, fb, k, exp_tx0, exp_tx6;
    logic rdy_seen;

    build_table();
    exp_tx0 = 0;
    exp_tx6 = 0;

    // Reset state of both instances.
    repeat (3) @(posedge aclk);
    #1;
    sel = 1'b0; #1; chk_reset_outputs("rst0");
    sel = 1'b1; #1; chk_reset_outputs("rst60");
    sel = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(posedge aclk); #1;

    // "123456789" without padding: known FCS bytes.
    pl = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_frame(pl, 0, fa);
    wait_out(13, "t1");
    if (got_d.size() >= 13) begin
      chk("t1_fcs0", 64'(got_d[9]),  64'h26);
      chk("t1_fcs1", 64'(got_d[10]), 64'h39);
      chk("t1_fcs2", 64'(got_d[11]), 64'hF4);
      chk("t1_fcs3", 64'(got_d[12]), 64'hCB);
    end
    build_exp(pl, 0, e);
    check_frame(e, "t1");
    settle();
    exp_tx0++;
    chk("t1_txcnt", 64'(tx_m), 64'(exp_tx0));

    // Single-byte frame.
    pl = {8'hAA};
    send_frame(pl, 0, fa);
    build_exp(pl, 0, e);
    check_frame(e, "t3");
    settle();
    exp_tx0++;
    chk("t3_txcnt", 64'(tx_m), 64'(exp_tx0));

    // Stray bytes in IDLE, then two back-to-back frames.
    for (int i = 0; i < 3; i++) drive_byte(8'($urandom), 1'b0, 1'b0, fa);
    last_cycs = {};
    rand_payload(10, pl);
    rand_payload(7, pb);
    send_frame(pl, 0, fa);
    send_frame(pb, 0, fb);
    build_exp(pl, 0, e);
    build_exp(pb, 0, eb);
    check_frame(e, "t5a");
    check_frame(eb, "t5b");
    if (last_cycs.size() > 0) chk("t5_b2b_cycle", 64'(fb), 64'(last_cycs[0]));
    else chk("t5_b2b_seen", 64'(last_cycs.size()), 64'd1);
    settle();
    exp_tx0 += 2;
    chk("t5_drop", 64'(drop_m), 64'd3);
    chk("t5_txcnt", 64'(tx_m), 64'(exp_tx0));

    // 14-byte frame padded to 60; input not ready during PAD/FCS.
    sel = 1'b1;
    @(posedge aclk); #1;
    rand_payload(14, pl);
    send_frame(pl, 0, fa);
    rdy_seen = 1'b0;
    k = 0;
    @(negedge aclk);
    while (!(m_valid && m_last) && k < 500) begin
      if (s_ready_m) rdy_seen = 1'b1;
      k++;
      @(negedge aclk);
    end
    chk("t2_ready_low", 64'(rdy_seen), 64'd0);
    @(posedge aclk); #1;
    build_exp(pl, 60, e);
    check_frame(e, "t2");
    settle();
    exp_tx6++;
    chk("t2_txcnt", 64'(tx_m), 64'(exp_tx6));

    // 100-byte frame with a randomly stalling MAC.
    rnd_ready = 1'b1;
    rand_payload(100, pl);
    send_frame(pl, 0, fa);
    build_exp(pl, 60, e);
    check_frame(e, "t4");
    rnd_ready = 1'b0;
    settle();
    exp_tx6++;
    chk("t4_txcnt", 64'(tx_m), 64'(exp_tx6));

    // Random lengths, input gaps and MAC stalls on both instances.
    for (int r = 0; r < 4; r++) begin
      sel = 1'(r);
      @(posedge aclk); #1;
      rnd_ready = 1'b1;
      rand_payload($urandom_range(1, 90), pl);
      send_frame(pl, 2, fa);
      build_exp(pl, sel ? 60 : 0, e);
      check_frame(e, "rnd");
      rnd_ready = 1'b0;
      settle();
      if (sel) exp_tx6++;
      else exp_tx0++;
      chk("rnd_txcnt", 64'(tx_m), 64'(sel ? exp_tx6 : exp_tx0));
    end

    // Reset during PAD, then a fresh 60-byte frame.
    sel = 1'b1;
    @(posedge aclk); #1;
    rand_payload(14, pl);
    send_frame(pl, 0, fa);
    repeat (5) @(posedge aclk);
    #1;
    areset = 1'b1;
    @(negedge aclk);
    chk_reset_outputs("t6_rst");
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    got_d = {}; got_f = {}; got_l = {};
    exp_tx0 = 0;
    exp_tx6 = 0;
    @(posedge aclk); #1;
    rand_payload(60, pl);
    send_frame(pl, 0, fa);
    build_exp(pl, 60, e);
    check_frame(e, "t6");
    settle();
    exp_tx6++;
    chk("t6_txcnt", 64'(tx_m), 64'(exp_tx6));
    sel = 1'b0;
    #1;
    chk("t6_txcnt0", 64'(tx_m), 64'(exp_tx0));
    chk("t6_drop0", 64'(drop_m), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
